// File: rtl/me_pkg.sv
// Shared types and default dimensions for the integer motion-search controller.
package me_pkg;

    localparam int ME_REF_BEAT_W  = 256;
    localparam int ME_CUR_BEAT_W  = 512;
    localparam int ME_SAD32_W     = 16;
    localparam int ME_SEARCH_COLS = 16;
    localparam int ME_SEARCH_ROWS = 16;
    localparam int ME_REF_PRELOAD = 32;
    localparam int ME_CUR_BEATS   = 16;

    typedef enum logic [2:0] {
        IDLE,
        PRE_REF,
        PRE_CUR,
        SEARCH,
        DRAIN,
        FINISH
    } me_state_t;

endpackage

// File: rtl/me_min_tracker.sv
// Running minimum of SAD32x32 results with the candidate position that produced it.
module me_min_tracker
    import me_pkg::*;
#(
    parameter int SEARCH_COLS = ME_SEARCH_COLS,
    parameter int SEARCH_ROWS = ME_SEARCH_ROWS,
    parameter int SAD_W       = ME_SAD32_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           enable,
    input  logic                           sad_in_valid,
    input  logic [SAD_W-1:0]               sad_in,
    output logic [SAD_W-1:0]               min_sad,
    output logic [$clog2(SEARCH_COLS)-1:0] min_col,
    output logic [$clog2(SEARCH_ROWS)-1:0] min_row,
    output logic                           all_seen
);

    localparam int CW = $clog2(SEARCH_COLS);
    localparam int RW = $clog2(SEARCH_ROWS);

    logic [CW-1:0] res_col;
    logic [RW-1:0] res_row;
    logic          accept;
    logic          last;

    // Results beyond the final candidate are dropped so a late extra beat cannot move the minimum.
    assign accept = enable & sad_in_valid & ~all_seen;
    assign last   = (res_col == CW'(SEARCH_COLS - 1)) && (res_row == RW'(SEARCH_ROWS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_sad  <= '1;
            min_col  <= '0;
            min_row  <= '0;
            res_col  <= '0;
            res_row  <= '0;
            all_seen <= 1'b0;
        end else if (clear) begin
            min_sad  <= '1;
            min_col  <= '0;
            min_row  <= '0;
            res_col  <= '0;
            res_row  <= '0;
            all_seen <= 1'b0;
        end else if (accept) begin
            // Strict compare keeps the earliest candidate on ties.
            if (sad_in < min_sad) begin
                min_sad <= sad_in;
                min_col <= res_col;
                min_row <= res_row;
            end
            if (last) begin
                all_seen <= 1'b1;
            end
            if (res_col == CW'(SEARCH_COLS - 1)) begin
                res_col <= '0;
                res_row <= res_row + 1'b1;
            end else begin
                res_col <= res_col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/me_search_ctrl.sv
// Full-search sequencer: preloads reference rows and the current block, walks every
// candidate position through the datapath and reports the minimum SAD32x32.
module me_search_ctrl
    import me_pkg::*;
#(
    parameter int SEARCH_COLS = ME_SEARCH_COLS,
    parameter int SEARCH_ROWS = ME_SEARCH_ROWS,
    parameter int REF_PRELOAD = ME_REF_PRELOAD,
    parameter int CUR_BEATS   = ME_CUR_BEATS,
    parameter int SAD_W       = ME_SAD32_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           ref_valid,
    output logic                           ref_ready,
    input  logic                           cur_valid,
    output logic                           cur_ready,
    output logic                           ref_begin_prepare,
    output logic                           pe_begin_prepare,
    output logic                           ref_shift_en,
    output logic [$clog2(SEARCH_COLS)-1:0] search_column_count,
    output logic [$clog2(SEARCH_ROWS)-1:0] search_row_count,
    input  logic                           sad_in_valid,
    input  logic [SAD_W-1:0]               sad_in,
    output logic                           busy,
    output logic                           done,
    output logic [SAD_W-1:0]               best_sad,
    output logic [$clog2(SEARCH_COLS)-1:0] best_col,
    output logic [$clog2(SEARCH_ROWS)-1:0] best_row,
    output me_state_t                      fsm_state
);

    localparam int CW = $clog2(SEARCH_COLS);
    localparam int RW = $clog2(SEARCH_ROWS);
    localparam int BW = $clog2((REF_PRELOAD > CUR_BEATS) ? REF_PRELOAD : CUR_BEATS);

    me_state_t        state;
    logic [BW-1:0]    beat_cnt;
    logic [CW-1:0]    col_cnt;
    logic [RW-1:0]    row_cnt;
    logic             track_clear;
    logic             track_en;
    logic [SAD_W-1:0] min_sad;
    logic [CW-1:0]    min_col;
    logic [RW-1:0]    min_row;
    logic             all_seen;

    // Handshake: a beat transfers on a rising edge where *_valid and *_ready are both high;
    // ready depends only on state, so an upstream stall freezes the current phase.
    assign busy                = (state != IDLE);
    assign done                = (state == FINISH);
    assign ref_ready           = (state == PRE_REF) || (state == SEARCH);
    assign cur_ready           = (state == PRE_CUR);
    assign ref_begin_prepare   = (state == PRE_REF);
    assign pe_begin_prepare    = (state == PRE_CUR);
    assign ref_shift_en        = (state == SEARCH) & ref_valid;
    assign search_column_count = col_cnt;
    assign search_row_count    = row_cnt;
    assign fsm_state           = state;

    assign track_clear = abort | ((state == IDLE) & start);
    assign track_en    = (state == SEARCH) || (state == DRAIN);

    me_min_tracker #(
        .SEARCH_COLS(SEARCH_COLS),
        .SEARCH_ROWS(SEARCH_ROWS),
        .SAD_W      (SAD_W)
    ) u_min_tracker (
        .clk         (clk),
        .rst         (rst),
        .clear       (track_clear),
        .enable      (track_en),
        .sad_in_valid(sad_in_valid),
        .sad_in      (sad_in),
        .min_sad     (min_sad),
        .min_col     (min_col),
        .min_row     (min_row),
        .all_seen    (all_seen)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            col_cnt  <= '0;
            row_cnt  <= '0;
            best_sad <= '1;
            best_col <= '0;
            best_row <= '0;
        end else if (abort) begin
            state    <= IDLE;
            beat_cnt <= '0;
            col_cnt  <= '0;
            row_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (start) begin
                        state <= PRE_REF;
                    end
                end
                PRE_REF: begin
                    if (ref_valid) begin
                        if (beat_cnt == BW'(REF_PRELOAD - 1)) begin
                            beat_cnt <= '0;
                            state    <= PRE_CUR;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                PRE_CUR: begin
                    if (cur_valid) begin
                        if (beat_cnt == BW'(CUR_BEATS - 1)) begin
                            beat_cnt <= '0;
                            state    <= SEARCH;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                SEARCH: begin
                    if (ref_valid) begin
                        if (col_cnt == CW'(SEARCH_COLS - 1)) begin
                            col_cnt <= '0;
                            if (row_cnt == RW'(SEARCH_ROWS - 1)) begin
                                row_cnt <= '0;
                                state   <= DRAIN;
                            end else begin
                                row_cnt <= row_cnt + 1'b1;
                            end
                        end else begin
                            col_cnt <= col_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // The minimum is final once every result is in, so it is published here
                    // and is already stable while done is high.
                    if (all_seen) begin
                        best_sad <= min_sad;
                        best_col <= min_col;
                        best_row <= min_row;
                        state    <= FINISH;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/me_search_ctrl.md
Name: me_search_ctrl

Overview:
Sequencer for the basic-layer integer motion-search datapath (reference-row buffer plus PE array producing SAD4x8..SAD32x32).
- Runs one full-search pass per start pulse:
  - preloads reference rows,
  - loads the 32x32 current block,
  - steps the datapath through every candidate position, supplying search_column_count and search_row_count,
  - tracks the minimum SAD32x32 and its candidate position.
- Sits between the fetch/DMA streams and the basic_layer_search datapath.

Parameters:
SEARCH_COLS, 16, candidate columns per search row (power of 2)
SEARCH_ROWS, 16, candidate rows (power of 2)
REF_PRELOAD, 32, reference beats (256-bit, 32 pixels) loaded before search
CUR_BEATS, 16, current-block beats (512-bit, 64 pixels) per 32x32 block
SAD_W, 16, SAD32x32 width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse, begins a pass (accepted in IDLE only)
abort  in  1  synchronous abort, returns to IDLE
ref_valid  in  1  reference beat available
ref_ready  out  1  controller accepts reference beat
cur_valid  in  1  current-block beat available
cur_ready  out  1  controller accepts current beat
ref_begin_prepare  out  1  datapath reference-buffer load enable
pe_begin_prepare  out  1  datapath PE current-pixel load enable
ref_shift_en  out  1  one candidate step (accepted ref beat during SEARCH)
search_column_count  out  clog2(SEARCH_COLS)  candidate column under evaluation
search_row_count  out  clog2(SEARCH_ROWS)  candidate row under evaluation
sad_in_valid  in  1  datapath SAD32x32 result valid
sad_in  in  SAD_W  datapath SAD32x32
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, pass complete
best_sad  out  SAD_W  minimum SAD of last completed pass
best_col  out  clog2(SEARCH_COLS)  column of minimum
best_row  out  clog2(SEARCH_ROWS)  row of minimum

Behaviour:
- Reset (async, rst=1): state=IDLE, all counters 0, all 1-bit outputs 0, best_sad all-ones, best_col and best_row 0.
- States: IDLE, PRE_REF, PRE_CUR, SEARCH, DRAIN, FINISH.
- IDLE:
  - start=1 -> PRE_REF next cycle.
  - On entry to PRE_REF, the internal running minimum is cleared to all-ones and the result counters are cleared.
  - best_* outputs hold their values until FINISH of the next pass.
- PRE_REF:
  - ref_ready=1, ref_begin_prepare=1.
  - Beat count increments on ref_valid&ref_ready.
  - On the REF_PRELOAD-th beat -> PRE_CUR.
- PRE_CUR:
  - cur_ready=1, pe_begin_prepare=1.
  - On the CUR_BEATS-th accepted beat -> SEARCH.
- SEARCH:
  - ref_ready=1; each accepted beat pulses ref_shift_en combinationally in the same cycle.
  - After each accepted beat, the column counter increments; it wraps from SEARCH_COLS-1 to 0 and increments the row counter.
  - Accepting candidate (SEARCH_ROWS-1, SEARCH_COLS-1) -> DRAIN; both counters return to 0.
- Stalls: ref_valid=0 or cur_valid=0 stalls the current phase; nothing advances and no outputs change.
- Result tracking (SEARCH and DRAIN only; sad_in_valid is ignored in other states):
  - The result column/row counter advances per sad_in_valid in the same wrap order.
  - Update rule: if sad_in < running_min, load sad_in and the result position. Strict compare, so ties keep the earliest candidate.
- DRAIN exit: when result count reaches SEARCH_COLS*SEARCH_ROWS -> FINISH.
  - The result counter is independent of pipeline latency.
  - If the final result arrives while still in SEARCH, FINISH follows DRAIN after one cycle.
- FINISH (1 cycle): copy the running minimum to best_sad/best_col/best_row, done=1, -> IDLE.
- Simultaneous events:
  - start during busy: ignored.
  - abort has priority over every transition: next state IDLE, all counters 0, no done, best_* unchanged.
  - abort together with start in IDLE: stays IDLE.
- rst mid-pass: immediate return to reset values.
- Ready/enable outputs are pure functions of state, with no combinational dependence on the *_valid inputs. Exception: ref_shift_en = SEARCH & ref_valid.

Decomposition:
- Shared package me_pkg:
  - state enum (IDLE..FINISH),
  - ME_REF_BEAT_W=256, ME_CUR_BEAT_W=512, ME_SAD32_W=16,
  - default search dimensions.
- One natural sub-module: me_min_tracker, holding the running minimum, result column/row counters and the strict-less compare. The FSM and phase counters stay in the top.

Test Plan:
1. Assert rst for 3 cycles, then release -> busy=0, done=0, ready outputs 0, best_sad=16'hFFFF, counters 0.
2. Nominal run: start, valids held high, sad_in=1000 for all results except result 53 (row 3, col 5)=17, results delayed 4 cycles -> PRE_REF 32 cycles, PRE_CUR 16 cycles, SEARCH 256 cycles; done pulses once; best_sad=17, best_col=5, best_row=3.
3. Tie: results 20 and 200 both =9, all others 500 -> best_col=4, best_row=1, best_sad=9.
4. Backpressure: ref_valid toggles 1/0 during SEARCH -> ref_shift_en only on accepted beats; at col=15, the next beat gives col=0 with row+1; SEARCH lasts 512 cycles; result unchanged.
5. Abort when row=7: next cycle IDLE, no done, best_* retain the previous pass; a new start then completes a clean pass with correct best.
6. Async rst asserted mid-PRE_CUR (not on a clock edge) -> outputs reach reset values before the next edge; start in the same cycle as abort is ignored.
